// File: rtl/opb_single_master_arbiter_if.sv
// Bundles the bridge-master request/address/data signals, the per-slave
// responses and the shared OPB outputs of the single-master arbiter.
interface opb_single_master_arbiter_if #(
   parameter int NUM_SLAVES = 4
);
   logic                       M_request;
   logic                       M_busLock;
   logic                       M_select;
   logic                       M_RNW;
   logic [0:3]                 M_BE;
   logic                       M_seqAddr;
   logic [0:31]                M_ABus;
   logic [0:31]                M_DBus;

   logic                       OPB_MGrant;
   logic                       OPB_select;
   logic                       OPB_RNW;
   logic [0:3]                 OPB_BE;
   logic                       OPB_seqAddr;
   logic [0:31]                OPB_ABus;
   logic [0:31]                OPB_DBus;
   logic                       OPB_xferAck;
   logic                       OPB_errAck;
   logic                       OPB_retry;
   logic                       OPB_timeout;

   logic [NUM_SLAVES-1:0]      Sl_xferAck;
   logic [NUM_SLAVES-1:0]      Sl_errAck;
   logic [NUM_SLAVES-1:0]      Sl_retry;
   logic [NUM_SLAVES-1:0]      Sl_toutSup;
   logic [NUM_SLAVES*32-1:0]   Sl_DBus;

   // Environment side: drives master requests and slave responses.
   modport master (
      output M_request, M_busLock, M_select, M_RNW, M_BE, M_seqAddr, M_ABus, M_DBus,
      output Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, Sl_DBus,
      input  OPB_MGrant, OPB_select, OPB_RNW, OPB_BE, OPB_seqAddr, OPB_ABus,
      input  OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout
   );

   // Arbiter side.
   modport slave (
      input  M_request, M_busLock, M_select, M_RNW, M_BE, M_seqAddr, M_ABus, M_DBus,
      input  Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, Sl_DBus,
      output OPB_MGrant, OPB_select, OPB_RNW, OPB_BE, OPB_seqAddr, OPB_ABus,
      output OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout
   );
endinterface

// File: rtl/opb_single_master_arbiter.sv
// Single-master OPB arbiter: grant FSM, master gating, slave response OR,
// bus timeout generation and saturating debug counters.
module opb_single_master_arbiter #(
   parameter int NUM_SLAVES     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   opb_single_master_arbiter_if.slave bus,
   output logic [15:0]             xfer_count,
   output logic [7:0]              tout_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      OWN   = 2'd2
   } state_t;

   localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t       state_r;
   state_t       state_nxt_s;
   logic         grant_r;
   logic         own_s;
   logic         sel_s;
   logic         xack_s;
   logic         eack_s;
   logic         retry_s;
   logic         multi_s;
   logic         tclr_s;
   logic [7:0]   tcnt_inc_s;
   logic [4:0]   ack_cnt_s;
   logic [31:0]  slv_dbus_s;
   logic [31:0]  mst_dbus_s;
   logic [7:0]   tcnt_r;
   logic         tout_r;
   logic         done_r;
   logic [15:0]  xfer_cnt_r;
   logic [7:0]   tout_cnt_r;

   // State register and registered grant pulse.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_r <= IDLE;
         grant_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= (state_nxt_s == GRANT);
      end
   end

   // Next-state logic; bus lock pins ownership regardless of request.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.M_request) state_nxt_s = GRANT;
            else               state_nxt_s = IDLE;
         end
         GRANT: state_nxt_s = OWN;
         OWN: begin
            if (!bus.M_request && !bus.M_select && !bus.M_busLock) state_nxt_s = IDLE;
            else                                                    state_nxt_s = OWN;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Master gating and OR-reduction of slave responses.
   always_comb begin
      own_s      = (state_r == OWN);
      sel_s      = bus.M_select & own_s;
      xack_s     = |bus.Sl_xferAck;
      eack_s     = |bus.Sl_errAck;
      retry_s    = |bus.Sl_retry;
      ack_cnt_s  = 5'd0;
      slv_dbus_s = 32'd0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         ack_cnt_s  = ack_cnt_s + 5'(bus.Sl_xferAck[i]);
         slv_dbus_s = slv_dbus_s | bus.Sl_DBus[i*32 +: 32];
      end
      multi_s = (ack_cnt_s > 5'd1);
      if (sel_s && !bus.M_RNW) mst_dbus_s = bus.M_DBus;
      else                     mst_dbus_s = 32'd0;
      tclr_s     = !sel_s | xack_s | eack_s | retry_s | (|bus.Sl_toutSup);
      tcnt_inc_s = tcnt_r + 8'd1;
   end

   assign bus.OPB_MGrant  = grant_r;
   assign bus.OPB_select  = sel_s;
   assign bus.OPB_RNW     = sel_s ? bus.M_RNW     : 1'b0;
   assign bus.OPB_BE      = sel_s ? bus.M_BE      : 4'd0;
   assign bus.OPB_seqAddr = sel_s ? bus.M_seqAddr : 1'b0;
   assign bus.OPB_ABus    = sel_s ? bus.M_ABus    : 32'd0;
   assign bus.OPB_DBus    = mst_dbus_s | slv_dbus_s;
   assign bus.OPB_xferAck = xack_s;
   assign bus.OPB_errAck  = eack_s | multi_s;
   assign bus.OPB_retry   = retry_s;
   assign bus.OPB_timeout = tout_r;

   // Timeout counter; done_r blocks a second pulse until select drops.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         tcnt_r <= 8'd0;
         tout_r <= 1'b0;
         done_r <= 1'b0;
      end else if (tclr_s) begin
         tcnt_r <= 8'd0;
         tout_r <= 1'b0;
         if (!sel_s) done_r <= 1'b0;
         else        done_r <= done_r;
      end else if (!done_r) begin
         tcnt_r <= tcnt_inc_s;
         tout_r <= (tcnt_inc_s == TOUT_LAST);
         done_r <= (tcnt_inc_s == TOUT_LAST);
      end else begin
         tout_r <= 1'b0;
      end
   end

   // Saturating debug counters.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         xfer_cnt_r <= 16'd0;
         tout_cnt_r <= 8'd0;
      end else begin
         if (xack_s && sel_s) xfer_cnt_r <= sat_inc16(xfer_cnt_r);
         else                 xfer_cnt_r <= xfer_cnt_r;
         if (tout_r) tout_cnt_r <= sat_inc8(tout_cnt_r);
         else        tout_cnt_r <= tout_cnt_r;
      end
   end

   assign xfer_count = xfer_cnt_r;
   assign tout_count = tout_cnt_r;

endmodule

// File: tb/tb_opb_single_master_arbiter.sv
// Directed self-checking bench for the single-master OPB arbiter.
module tb_opb_single_master_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] xfer_count;
   logic [7:0]  tout_count;
   int          n_checks;
   int          n_fails;

   opb_single_master_arbiter_if #(.NUM_SLAVES(4)) bus ();

   opb_single_master_arbiter #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
      .OPB_Clk    (clk),
      .OPB_Rst_n  (rst_n),
      .bus        (bus),
      .xfer_count (xfer_count),
      .tout_count (tout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset_state();
      rst_n = 1'b0;
      bus.M_request = 1'b0; bus.M_busLock = 1'b0; bus.M_select = 1'b1;
      bus.M_RNW = 1'b0; bus.M_BE = 4'hF; bus.M_seqAddr = 1'b1;
      bus.M_ABus = 32'h1111_2222; bus.M_DBus = 32'h3333_4444;
      bus.Sl_xferAck = 4'd0; bus.Sl_errAck = 4'd0; bus.Sl_retry = 4'd0;
      bus.Sl_toutSup = 4'd0; bus.Sl_DBus = 128'd0;
      #3;
      n_checks++; if (bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL reset_mgrant got %b exp 0", bus.OPB_MGrant); end
      n_checks++; if (bus.OPB_select !== 1'b0) begin n_fails++; $display("FAIL reset_select got %b exp 0", bus.OPB_select); end
      n_checks++; if (bus.OPB_ABus !== 32'd0) begin n_fails++; $display("FAIL reset_abus got %h exp 0", bus.OPB_ABus); end
      n_checks++; if (bus.OPB_DBus !== 32'd0) begin n_fails++; $display("FAIL reset_dbus got %h exp 0", bus.OPB_DBus); end
      n_checks++; if (bus.OPB_timeout !== 1'b0) begin n_fails++; $display("FAIL reset_timeout got %b exp 0", bus.OPB_timeout); end
      n_checks++; if (xfer_count !== 16'd0 || tout_count !== 8'd0) begin n_fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0", xfer_count, tout_count); end
      bus.M_select = 1'b0; bus.M_BE = 4'd0; bus.M_seqAddr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_grant();
      bus.M_request = 1'b1;
      #1;
      n_checks++; if (bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL grant_cyc0 got %b exp 0", bus.OPB_MGrant); end
      tick();
      bus.M_select = 1'b1;
      #1;
      n_checks++; if (bus.OPB_MGrant !== 1'b1) begin n_fails++; $display("FAIL grant_cyc1 got %b exp 1", bus.OPB_MGrant); end
      n_checks++; if (bus.OPB_select !== 1'b0) begin n_fails++; $display("FAIL grant_sel_in_grant got %b exp 0", bus.OPB_select); end
      tick();
      bus.M_ABus = 32'h0010_0004; bus.M_RNW = 1'b1; bus.M_BE = 4'hF;
      bus.M_DBus = 32'h1234_5678; bus.M_seqAddr = 1'b1;
      #1;
      n_checks++; if (bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL grant_cyc2 got %b exp 0", bus.OPB_MGrant); end
      n_checks++; if (bus.OPB_select !== 1'b1) begin n_fails++; $display("FAIL own_select got %b exp 1", bus.OPB_select); end
      n_checks++; if (bus.OPB_ABus !== 32'h0010_0004) begin n_fails++; $display("FAIL own_abus got %h exp 00100004", bus.OPB_ABus); end
      n_checks++; if (bus.OPB_RNW !== 1'b1 || bus.OPB_BE !== 4'hF || bus.OPB_seqAddr !== 1'b1) begin n_fails++; $display("FAIL own_ctrl got %b/%h/%b exp 1/f/1", bus.OPB_RNW, bus.OPB_BE, bus.OPB_seqAddr); end
      n_checks++; if (bus.OPB_DBus !== 32'd0) begin n_fails++; $display("FAIL read_no_wdata got %h exp 0", bus.OPB_DBus); end
   endtask

   task automatic test_read();
      tick();
      tick();
      bus.Sl_DBus[95:64] = 32'hDEAD_BEEF;
      bus.Sl_xferAck = 4'b0100;
      #1;
      n_checks++; if (bus.OPB_DBus !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL read_dbus got %h exp deadbeef", bus.OPB_DBus); end
      n_checks++; if (bus.OPB_xferAck !== 1'b1) begin n_fails++; $display("FAIL read_xferack got %b exp 1", bus.OPB_xferAck); end
      n_checks++; if (bus.OPB_errAck !== 1'b0) begin n_fails++; $display("FAIL read_errack got %b exp 0", bus.OPB_errAck); end
      tick();
      n_checks++; if (xfer_count !== 16'd1) begin n_fails++; $display("FAIL read_xfer_count got %0d exp 1", xfer_count); end
      n_checks++; if (bus.OPB_timeout !== 1'b0) begin n_fails++; $display("FAIL read_timeout got %b exp 0", bus.OPB_timeout); end
      bus.Sl_xferAck = 4'd0; bus.Sl_DBus = 128'd0; bus.M_select = 1'b0;
   endtask

   task automatic test_timeout();
      tick();
      bus.M_select = 1'b1; bus.M_RNW = 1'b0; bus.M_DBus = 32'hA5A5_0000;
      #1;
      n_checks++; if (bus.OPB_DBus !== 32'hA5A5_0000) begin n_fails++; $display("FAIL write_dbus got %h exp a5a50000", bus.OPB_DBus); end
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if (bus.OPB_timeout !== (k == 16)) begin
            n_fails++;
            $display("FAIL timeout_cyc%0d got %b exp %b", k, bus.OPB_timeout, (k == 16));
         end
         tick();
      end
      n_checks++; if (tout_count !== 8'd1) begin n_fails++; $display("FAIL tout_count got %0d exp 1", tout_count); end
      bus.M_select = 1'b0;
      tick();
   endtask

   task automatic test_suppress();
      logic seen;
      seen = 1'b0;
      bus.M_select = 1'b1; bus.Sl_toutSup = 4'b0001;
      for (int k = 0; k < 100; k++) begin
         if (bus.OPB_timeout === 1'b1) seen = 1'b1;
         tick();
      end
      n_checks++; if (seen !== 1'b0) begin n_fails++; $display("FAIL suppress_timeout got %b exp 0", seen); end
      n_checks++; if (tout_count !== 8'd1) begin n_fails++; $display("FAIL suppress_tout_count got %0d exp 1", tout_count); end
      bus.Sl_toutSup = 4'd0; bus.Sl_xferAck = 4'b0011;
      #1;
      n_checks++; if (bus.OPB_errAck !== 1'b1) begin n_fails++; $display("FAIL multi_ack_err got %b exp 1", bus.OPB_errAck); end
      n_checks++; if (bus.OPB_xferAck !== 1'b1) begin n_fails++; $display("FAIL multi_ack_xfer got %b exp 1", bus.OPB_xferAck); end
      tick();
      n_checks++; if (xfer_count !== 16'd2) begin n_fails++; $display("FAIL multi_xfer_count got %0d exp 2", xfer_count); end
      bus.Sl_xferAck = 4'd0; bus.Sl_errAck = 4'b1000; bus.Sl_retry = 4'b0010;
      #1;
      n_checks++; if (bus.OPB_errAck !== 1'b1 || bus.OPB_retry !== 1'b1) begin n_fails++; $display("FAIL err_retry_or got %b/%b exp 1/1", bus.OPB_errAck, bus.OPB_retry); end
      bus.Sl_errAck = 4'd0; bus.Sl_retry = 4'd0; bus.M_select = 1'b0;
      tick();
   endtask

   task automatic test_lock();
      logic grant_seen;
      logic tout_seen;
      grant_seen = 1'b0;
      tout_seen  = 1'b0;
      bus.M_busLock = 1'b1; bus.M_request = 1'b0; bus.M_select = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.OPB_MGrant === 1'b1) grant_seen = 1'b1;
      end
      n_checks++; if (grant_seen !== 1'b0) begin n_fails++; $display("FAIL lock_no_grant got %b exp 0", grant_seen); end
      bus.M_select = 1'b1;
      #1;
      n_checks++; if (bus.OPB_select !== 1'b1) begin n_fails++; $display("FAIL lock_still_own got %b exp 1", bus.OPB_select); end
      bus.M_select = 1'b0; bus.M_busLock = 1'b0;
      tick();
      bus.M_select = 1'b1; bus.M_ABus = 32'hCAFE_0010;
      #1;
      n_checks++; if (bus.OPB_select !== 1'b0) begin n_fails++; $display("FAIL idle_select got %b exp 0", bus.OPB_select); end
      n_checks++; if (bus.OPB_ABus !== 32'd0) begin n_fails++; $display("FAIL idle_abus got %h exp 0", bus.OPB_ABus); end
      for (int k = 0; k < 20; k++) begin
         if (bus.OPB_timeout === 1'b1) tout_seen = 1'b1;
         tick();
      end
      n_checks++; if (tout_seen !== 1'b0 || tout_count !== 8'd1) begin n_fails++; $display("FAIL idle_no_timeout got %b/%0d exp 0/1", tout_seen, tout_count); end
      bus.M_select = 1'b0;
   endtask

   task automatic test_midreset();
      bus.M_request = 1'b1;
      tick();
      tick();
      bus.M_select = 1'b1; bus.M_RNW = 1'b1; bus.Sl_xferAck = 4'b0001;
      tick();
      tick();
      tick();
      n_checks++; if (xfer_count !== 16'd5 || bus.OPB_select !== 1'b1) begin n_fails++; $display("FAIL pre_reset got %0d/%b exp 5/1", xfer_count, bus.OPB_select); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.OPB_select !== 1'b0 || bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL midreset_bus got %b/%b exp 0/0", bus.OPB_select, bus.OPB_MGrant); end
      n_checks++; if (xfer_count !== 16'd0 || tout_count !== 8'd0) begin n_fails++; $display("FAIL midreset_counts got %0d/%0d exp 0/0", xfer_count, tout_count); end
      bus.M_request = 1'b0; bus.M_select = 1'b0; bus.Sl_xferAck = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.M_request = 1'b1;
      #1;
      n_checks++; if (bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL regrant_cyc0 got %b exp 0", bus.OPB_MGrant); end
      tick();
      n_checks++; if (bus.OPB_MGrant !== 1'b1) begin n_fails++; $display("FAIL regrant_cyc1 got %b exp 1", bus.OPB_MGrant); end
      tick();
      n_checks++; if (bus.OPB_MGrant !== 1'b0) begin n_fails++; $display("FAIL regrant_cyc2 got %b exp 0", bus.OPB_MGrant); end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      test_reset_state();
      test_grant();
      test_read();
      test_timeout();
      test_suppress();
      test_lock();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/opb_single_master_arbiter.md
Name: opb_single_master_arbiter

Overview:
- Sits directly downstream of the EPB-to-OPB bridge master.
- Grants the OPB to that single master and gates master address, control and data onto the shared OPB.
- OR-reduces slave responses back to the master and generates the OPB bus timeout.
- Keeps saturating transfer and timeout counters for debug software registers.

Parameters:
NUM_SLAVES, 4, number of attached OPB slaves (1..16)
TIMEOUT_CYCLES, 16, cycles of select without ack/retry/toutSup before OPB_timeout (4..255)

Ports:
OPB_Clk  input  1  OPB clock; all logic on rising edge
OPB_Rst_n  input  1  asynchronous active-low reset
M_request  input  1  master bus request
M_busLock  input  1  master bus lock
M_select  input  1  master select
M_RNW  input  1  master read-not-write
M_BE  input  [0:3]  master byte enables
M_seqAddr  input  1  master sequential address
M_ABus  input  [0:31]  master address
M_DBus  input  [0:31]  master write data
OPB_MGrant  output  1  grant to master
OPB_select  output  1  gated select to slaves
OPB_RNW  output  1  gated RNW
OPB_BE  output  [0:3]  gated byte enables
OPB_seqAddr  output  1  gated seqAddr
OPB_ABus  output  [0:31]  gated address
OPB_DBus  output  [0:31]  OR of gated master write data and all slave data
OPB_xferAck  output  1  OR of slave xferAck
OPB_errAck  output  1  OR of slave errAck, or multi-ack error
OPB_retry  output  1  OR of slave retry
OPB_timeout  output  1  bus timeout pulse
Sl_xferAck  input  [NUM_SLAVES-1:0]  per-slave ack
Sl_errAck  input  [NUM_SLAVES-1:0]  per-slave error
Sl_retry  input  [NUM_SLAVES-1:0]  per-slave retry
Sl_toutSup  input  [NUM_SLAVES-1:0]  per-slave timeout suppress
Sl_DBus  input  [NUM_SLAVES*32-1:0]  slave read data, slave 0 in bits [31:0]
xfer_count  output  16  saturating count of completed OPB_xferAck cycles
tout_count  output  8  saturating count of OPB_timeout pulses

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; OPB_MGrant, OPB_timeout, timeout counter, xfer_count and tout_count all 0.
  - Gated outputs read 0 because ownership is 0.
- State machine: IDLE, GRANT, OWN.
  - IDLE -> GRANT when M_request=1.
  - GRANT lasts exactly one cycle with registered OPB_MGrant=1, then -> OWN. Grant latency is request sampled at edge n, grant high during cycle n+1.
  - OWN -> IDLE when M_request=0, M_select=0 and M_busLock=0 in the same cycle.
  - M_busLock=1 holds OWN regardless of M_request.
  - A new grant requires re-entering IDLE and a fresh MGrant pulse.
- Gating (combinational):
  - own = (state==OWN).
  - OPB_select = M_select & own.
  - OPB_RNW, OPB_BE, OPB_seqAddr and OPB_ABus equal the master value when OPB_select=1, else 0.
  - Master write data enters OPB_DBus only when OPB_select=1 and M_RNW=0.
  - M_select asserted outside OWN is ignored: no select reaches slaves and no timeout is counted.
- Response path (combinational):
  - OPB_xferAck, OPB_retry and OPB_DBus slave term are bitwise OR across slaves.
  - OPB_errAck = OR of Sl_errAck OR (more than one Sl_xferAck high in one cycle).
- Timeout:
  - An 8-bit counter clears when OPB_select=0 or when any Sl_xferAck, Sl_errAck, Sl_retry or Sl_toutSup is high.
  - Otherwise it increments while OPB_select=1.
  - When it reaches TIMEOUT_CYCLES-1 with no clear condition, OPB_timeout is registered high for exactly one cycle, asserting TIMEOUT_CYCLES cycles after the first select cycle.
  - After the pulse the counter holds and no further timeout fires until OPB_select drops.
  - Sl_toutSup held high suppresses the timeout indefinitely.
- Counters:
  - xfer_count increments on each cycle with OPB_xferAck=1 and OPB_select=1; saturates at 0xFFFF.
  - tout_count increments on each OPB_timeout pulse; saturates at 0xFF.
  - Neither counter wraps.
- Mid-operation reset: grant, ownership, timeout pulse and counters clear immediately (asynchronously); gated outputs drop to 0.

Test Plan:
- Basic grant: M_request high at cycle 0 -> OPB_MGrant=1 only in cycle 1; OWN from cycle 2; M_select then propagates with M_ABus=0x00100004 on OPB_ABus.
- Read: slave 2 drives Sl_DBus=0xDEADBEEF with Sl_xferAck[2] on the 3rd select cycle -> OPB_DBus=0xDEADBEEF, OPB_xferAck=1, xfer_count 0->1, no timeout.
- Timeout: select held with no slave response, TIMEOUT_CYCLES=16 -> OPB_timeout high exactly in the 16th select cycle, then stays low while select remains high; tout_count=1.
- Suppress and multi-ack:
  - Sl_toutSup[0] held for 100 cycles -> no timeout.
  - Sl_xferAck[0] and Sl_xferAck[1] high in the same cycle -> OPB_errAck=1.
- Lock and non-owner:
  - M_busLock=1 with request dropped -> stays OWN, no new MGrant.
  - M_select asserted in IDLE -> OPB_select=0 and no timeout counting.
- Reset mid-transfer: OPB_Rst_n low while selected, xfer_count=5 -> OPB_select, OPB_MGrant and counters all 0 immediately; after release, a new request produces a normal grant pulse.
